// File: rtl/dlfloat16_sqrt_seq.sv
// Lane sequencer for the shared combinational DLfloat16 sqrt unit: issues the
// active lanes of a SIMD word one per cycle and packs results and flags back.
module dlfloat16_sqrt_seq #(
    parameter int          LANES   = 4,
    parameter logic [3:0]  OP_SQRT = 4'b0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_data,
    input  logic [LANES-1:0]      in_mask,
    output logic [3:0]            sq_ena,
    output logic [15:0]           sq_dl_in,
    input  logic [19:0]           sq_dl_out,
    input  logic [4:0]            sq_exc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [20*LANES-1:0]   out_data,
    output logic [5*LANES-1:0]    out_exc_lane,
    output logic [4:0]            out_exc_or,
    output logic [1:0]            dbg_state
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q;
    logic [PW-1:0]         ptr_q;
    logic [16*LANES-1:0]   data_q;
    logic [LANES-1:0]      mask_q;
    logic [20*LANES-1:0]   out_data_q;
    logic [5*LANES-1:0]    out_exc_lane_q;
    logic [4:0]            out_exc_or_q;
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic [3:0]            sq_ena_q;
    logic [15:0]           sq_dl_in_q;
    logic [PW:0]           first_d;
    logic [PW:0]           next_d;

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [PW:0] find_lane(input logic [LANES-1:0] mask, input int start);
        logic [PW:0] res;
        res = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i >= start && mask[i]) begin
                res = {1'b1, i[PW-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        first_d = find_lane(in_mask, 0);
        next_d  = find_lane(mask_q, int'(ptr_q) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            out_data_q     <= '0;
            out_exc_lane_q <= '0;
            out_exc_or_q   <= '0;
            out_valid_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            sq_ena_q       <= '0;
            sq_dl_in_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q         <= in_data;
                        mask_q         <= in_mask;
                        out_data_q     <= '0;
                        out_exc_lane_q <= '0;
                        out_exc_or_q   <= '0;
                        in_ready_q     <= 1'b0;
                        ptr_q          <= first_d[PW-1:0];
                        if (first_d[PW]) begin
                            state_q    <= RUN;
                            sq_ena_q   <= OP_SQRT;
                            sq_dl_in_q <= in_data[16*int'(first_d[PW-1:0]) +: 16];
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The unit is combinational, so the result for the lane on
                    // sq_dl_in this cycle is captured at this edge.
                    out_data_q[20*int'(ptr_q) +: 20]    <= sq_dl_out;
                    out_exc_lane_q[5*int'(ptr_q) +: 5]  <= sq_exc;
                    out_exc_or_q                        <= out_exc_or_q | sq_exc;
                    if (next_d[PW]) begin
                        ptr_q      <= next_d[PW-1:0];
                        sq_dl_in_q <= data_q[16*int'(next_d[PW-1:0]) +: 16];
                    end else begin
                        state_q     <= DONE;
                        ptr_q       <= '0;
                        sq_ena_q    <= '0;
                        sq_dl_in_q  <= '0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    sq_ena_q    <= '0;
                    sq_dl_in_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign sq_ena       = sq_ena_q;
    assign sq_dl_in     = sq_dl_in_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_exc_lane = out_exc_lane_q;
    assign out_exc_or   = out_exc_or_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dlfloat16_sqrt_seq.sv
// Directed bench for dlfloat16_sqrt_seq with a stub sqrt unit whose results
// are easy to hand-compute: non-negative x -> {4'h5, x}, negative -> NaN + flag.
module tb_dlfloat16_sqrt_seq;

    localparam logic [3:0] OP_SQRT = 4'b0100;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_mask;
    logic [3:0]  sq_ena;
    logic [15:0] sq_dl_in;
    logic [19:0] sq_dl_out;
    logic [4:0]  sq_exc;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] out_data;
    logic [19:0] out_exc_lane;
    logic [4:0]  out_exc_or;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_fail;

    dlfloat16_sqrt_seq #(.LANES(4), .OP_SQRT(OP_SQRT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
        .sq_ena(sq_ena), .sq_dl_in(sq_dl_in), .sq_dl_out(sq_dl_out), .sq_exc(sq_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc_lane(out_exc_lane), .out_exc_or(out_exc_or), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub sqrt unit; a garbage value while not enabled exposes stray captures.
    always_comb begin
        sq_dl_out = 20'hBAD00;
        sq_exc    = 5'b00001;
        if (sq_ena == OP_SQRT) begin
            if (sq_dl_in[15]) begin
                sq_dl_out = 20'h7FE00;
                sq_exc    = 5'b10000;
            end else begin
                sq_dl_out = {4'h5, sq_dl_in};
                sq_exc    = 5'b00000;
            end
        end
    end

    // Issued operands, sampled mid-cycle
    logic [15:0] issue_q[$];
    logic [15:0] exp_q[$];
    always @(negedge clk) begin
        if (rst_n && sq_ena == OP_SQRT) issue_q.push_back(sq_dl_in);
    end

    typedef struct {
        logic [63:0] data;
        logic [3:0]  mask;
        logic [79:0] exp_data;
        logic [19:0] exp_exc;
        logic [4:0]  exp_or;
        int          exp_n;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_in_ready();
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_timeout", 80'(in_ready), 80'd1);
    endtask

    // Drives one word, returns edges from acceptance to out_valid.
    task automatic send_word(input logic [63:0] d, input logic [3:0] m, output int lat);
        @(negedge clk);
        wait_in_ready();
        issue_q.delete();
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_out_valid_low", 80'(out_valid), 80'd0);
        chk("hs_in_ready_high", 80'(in_ready), 80'd1);
    endtask

    task automatic run_vec(input int idx, input bit backpressure);
        int          lat;
        logic [79:0] held;
        vec_t        v;
        v = vecs[idx];
        exp_q.delete();
        for (int l = 0; l < 4; l++) begin
            if (v.mask[l]) exp_q.push_back(v.data[16*l +: 16]);
        end
        send_word(v.data, v.mask, lat);
        chk($sformatf("v%0d_latency", idx), 80'(lat), 80'(v.exp_n));
        chk($sformatf("v%0d_out_data", idx), out_data, v.exp_data);
        chk($sformatf("v%0d_exc_lane", idx), 80'(out_exc_lane), 80'(v.exp_exc));
        chk($sformatf("v%0d_exc_or", idx), 80'(out_exc_or), 80'(v.exp_or));
        chk($sformatf("v%0d_issue_cnt", idx), 80'(issue_q.size()), 80'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < issue_q.size(); k++) begin
            chk($sformatf("v%0d_issue%0d", idx, k), 80'(issue_q[k]), 80'(exp_q[k]));
        end
        if (backpressure) begin
            held = out_data;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                in_valid = c[0];
                in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
                in_mask  = 4'b1111;
                @(posedge clk);
                #1;
                chk("bp_out_valid", 80'(out_valid), 80'd1);
                chk("bp_in_ready", 80'(in_ready), 80'd0);
                chk("bp_out_data", out_data, held);
                chk("bp_state_done", 80'(dbg_state), 80'd2);
            end
            in_valid = 1'b0;
        end
        handshake();
        chk($sformatf("v%0d_hold_in_idle", idx), out_data, v.exp_data);
        issue_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("v%0d_idle_no_valid", idx), 80'(out_valid), 80'd0);
        chk($sformatf("v%0d_idle_no_issue", idx), 80'(issue_q.size()), 80'd0);
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        out_ready = 1'b0;

        vecs[0] = '{64'h3E00_3E00_3E00_3E00, 4'b1111, 80'h53E00_53E00_53E00_53E00, 20'h00000, 5'h00, 4};
        vecs[1] = '{64'h4480_1111_4480_2222, 4'b1010, 80'h54480_00000_54480_00000, 20'h00000, 5'h00, 2};
        vecs[2] = '{64'h3E00_C440_3E00_3E00, 4'b1111, 80'h53E00_7FE00_53E00_53E00, 20'h04000, 5'h10, 4};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 4'b0000, 80'h00000_00000_00000_00000, 20'h00000, 5'h00, 0};
        vecs[4] = '{64'h4000_4000_4000_8123, 4'b0001, 80'h00000_00000_00000_7FE00, 20'h00010, 5'h10, 1};
        vecs[5] = '{64'h4000_0000_0000_0000, 4'b1000, 80'h54000_00000_00000_00000, 20'h00000, 5'h00, 1};
        vecs[6] = '{64'h1111_3C00_C000_2222, 4'b0110, 80'h00000_53C00_7FE00_00000, 20'h00200, 5'h10, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 80'(out_valid), 80'd0);
        chk("rst_sq_ena", 80'(sq_ena), 80'd0);
        chk("rst_out_data", out_data, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 80'(in_ready), 80'd1);
        chk("rst_state_idle", 80'(dbg_state), 80'd0);

        run_vec(0, 1'b1);
        for (int i = 1; i < 7; i++) run_vec(i, 1'b0);

        // Reset in the middle of a full word discards it.
        @(negedge clk);
        wait_in_ready();
        in_data  = 64'h3E00_3E00_3E00_3E00;
        in_mask  = 4'b1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_state_run", 80'(dbg_state), 80'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sq_ena", 80'(sq_ena), 80'd0);
        chk("mid_rst_sq_dl_in", 80'(sq_dl_in), 80'd0);
        chk("mid_rst_out_data", out_data, 80'd0);
        chk("mid_rst_exc_lane", 80'(out_exc_lane), 80'd0);
        chk("mid_rst_exc_or", 80'(out_exc_or), 80'd0);
        chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_q.delete();
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        chk("post_rst_no_valid", 80'(lat), 80'd0);
        chk("post_rst_no_issue", 80'(issue_q.size()), 80'd0);
        chk("post_rst_in_ready", 80'(in_ready), 80'd1);

        // Back-to-back after reset still works.
        run_vec(6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
